mips_control_fsm: RTL and testbench

Multicycle main controller for the MIPS processor: decodes the opcode/funct of the instruction held in the instruction register and steps through fetch/decode/execute/memory/writeback phases. It drives the same datapath controls as the single-cycle top level (ALUControl, RegWrite, MemWrite, RegDst, ALUSrc, MemtoReg) plus the multicycle-only enables (PC, IR, address select). It sits directly upstream of the datapath and replaces externally driven control pins with sequenced ones. It also keeps a retired-instruction counter for bring-up.

---
 rtl/mips_control_fsm.sv | 160 ++++++++++++++++
 tb/tb_mips_control_fsm.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mips_control_fsm.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions. Define MIPS_CTRL_JUMP_EN to decode j (Op 000010).
module mips_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             master_clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             stall,
    output logic             PCEn,
    output logic             IorD,
    output logic             IRWrite,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             MemtoReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic [2:0]       ALUControl,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
        EXEC, ALUWB, BRANCH, ADDIEX, ADDIWB
`ifdef MIPS_CTRL_JUMP_EN
        , JUMP
`endif
    } state_t;

    state_t           state_q, state_d, nxt;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pcen_c, irw_c, mw_c, rw_c, ill_c;
    logic             hold;

    always_ff @(posedge master_clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        nxt        = FETCH;
        pcen_c     = 1'b0;
        irw_c      = 1'b0;
        mw_c       = 1'b0;
        rw_c       = 1'b0;
        ill_c      = 1'b0;
        IorD       = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUControl = 3'b010;
        case (state_q)
            FETCH: begin
                irw_c   = 1'b1;
                pcen_c  = 1'b1;
                ALUSrcB = 2'b01;
                nxt     = DECODE;
            end
            DECODE: begin
                // ALU precomputes the branch target while the opcode is decoded
                ALUSrcB = 2'b10;
                case (Op)
                    6'b100011, 6'b101011: nxt = MEMADR;
                    6'b000000:            nxt = EXEC;
                    6'b000100:            nxt = BRANCH;
                    6'b001000:            nxt = ADDIEX;
`ifdef MIPS_CTRL_JUMP_EN
                    6'b000010:            nxt = JUMP;
`endif
                    default: begin
                        nxt   = FETCH;
                        ill_c = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = (Op == 6'b101011) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD = 1'b1;
                nxt  = MEMWB;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                rw_c     = 1'b1;
            end
            MEMWR: begin
                IorD = 1'b1;
                mw_c = 1'b1;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                nxt     = ALUWB;
                case (Funct)
                    6'b100000: ALUControl = 3'b010;
                    6'b100010: ALUControl = 3'b110;
                    6'b100100: ALUControl = 3'b000;
                    6'b100101: ALUControl = 3'b001;
                    6'b101010: ALUControl = 3'b111;
                    default: begin
                        nxt   = FETCH;
                        ill_c = 1'b1;
                    end
                endcase
            end
            ALUWB: begin
                RegDst = 1'b1;
                rw_c   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = 3'b110;
                PCSrc      = 2'b01;
                pcen_c     = Zero;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                nxt     = ADDIWB;
            end
            ADDIWB: rw_c = 1'b1;
`ifdef MIPS_CTRL_JUMP_EN
            JUMP: begin
                PCSrc  = 2'b10;
                pcen_c = 1'b1;
            end
`endif
            default: nxt = FETCH;
        endcase

        state_d = stall ? state_q : nxt;
        cnt_d   = cnt_q;
        if (!stall && state_q != FETCH && nxt == FETCH)
            cnt_d = cnt_q + CNT_W'(1);
    end

    // Write enables are suppressed while stalled or held in reset so nothing commits twice
    assign hold        = stall | reset;
    assign PCEn        = pcen_c & ~hold;
    assign IRWrite     = irw_c  & ~hold;
    assign MemWrite    = mw_c   & ~hold;
    assign RegWrite    = rw_c   & ~hold;
    assign illegal_op  = ill_c  & ~hold;
    assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_control_fsm.sv
// Table-driven bench for mips_control_fsm: per-cycle vectors of inputs and expected
// control outputs, plus a hand-written reset-mid-instruction sequence.
module tb_mips_control_fsm;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [5:0]    Op, Funct;
    logic          Zero, stall;
    logic          PCEn, IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA;
    logic [1:0]    ALUSrcB, PCSrc;
    logic [2:0]    ALUControl;
    logic          illegal_op;
    logic [CW-1:0] instr_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_control_fsm #(.CNT_W(CW)) dut (
        .master_clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero), .stall(stall),
        .PCEn(PCEn), .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSrc(PCSrc), .ALUControl(ALUControl), .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    // {PCEn,IorD,IRWrite,MemWrite,RegWrite,RegDst,MemtoReg,ALUSrcA,ALUSrcB,PCSrc,ALUControl,illegal_op}
    localparam logic [15:0] S_FETCH  = 16'hA044, S_FETCH_ST = 16'h0044;
    localparam logic [15:0] S_DEC    = 16'h0084, S_DEC_ILL  = 16'h0085;
    localparam logic [15:0] S_MEMADR = 16'h0184, S_MEMRD    = 16'h4004;
    localparam logic [15:0] S_MEMWB  = 16'h0A04, S_MEMWR    = 16'h5004;
    localparam logic [15:0] S_MEMWR_ST = 16'h4004;
    localparam logic [15:0] S_EX_SUB = 16'h010C, S_EX_AND   = 16'h0100;
    localparam logic [15:0] S_EX_SLT = 16'h010E, S_EX_ILL   = 16'h0105;
    localparam logic [15:0] S_ALUWB  = 16'h0C04;
    localparam logic [15:0] S_BR_T   = 16'h811C, S_BR_N     = 16'h011C;
    localparam logic [15:0] S_ADDIEX = 16'h0184, S_ADDIWB   = 16'h0804;
    localparam logic [15:0] S_JUMP   = 16'h8024;

    typedef struct {
        logic [5:0]    op;
        logic [5:0]    funct;
        logic          zero;
        logic          stall;
        logic [15:0]   exp;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [15:0] outs();
        return {PCEn, IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg, ALUSrcA,
                ALUSrcB, PCSrc, ALUControl, illegal_op};
    endfunction

    task automatic add(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input logic st, input logic [15:0] e, input logic [CW-1:0] c);
        vec_t v;
        v.op = op; v.funct = fn; v.zero = z; v.stall = st; v.exp = e; v.cnt = c;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] e,
                       input logic [CW-1:0] c);
        checks++;
        if (outs() !== e) begin
            errors++;
            $display("FAIL %s[%0d] outputs: got %h want %h", name, idx, outs(), e);
        end
        checks++;
        if (instr_count !== c) begin
            errors++;
            $display("FAIL %s[%0d] instr_count: got %0d want %0d", name, idx, instr_count, c);
        end
    endtask

    initial begin
        // lw
        add(6'h23, 0, 0, 0, S_FETCH, 0);   add(6'h23, 0, 0, 0, S_DEC, 0);
        add(6'h23, 0, 0, 0, S_MEMADR, 0);  add(6'h23, 0, 0, 0, S_MEMRD, 0);
        add(6'h23, 0, 0, 0, S_MEMWB, 0);
        // R-type sub
        add(0, 6'h22, 0, 0, S_FETCH, 1);   add(0, 6'h22, 0, 0, S_DEC, 1);
        add(0, 6'h22, 0, 0, S_EX_SUB, 1);  add(0, 6'h22, 0, 0, S_ALUWB, 1);
        // beq taken / not taken
        add(6'h04, 0, 1, 0, S_FETCH, 2);   add(6'h04, 0, 1, 0, S_DEC, 2);
        add(6'h04, 0, 1, 0, S_BR_T, 2);
        add(6'h04, 0, 0, 0, S_FETCH, 3);   add(6'h04, 0, 0, 0, S_DEC, 3);
        add(6'h04, 0, 0, 0, S_BR_N, 3);
        // sw with a 3-cycle stall in MEMWR
        add(6'h2B, 0, 0, 0, S_FETCH, 4);   add(6'h2B, 0, 0, 0, S_DEC, 4);
        add(6'h2B, 0, 0, 0, S_MEMADR, 4);
        add(6'h2B, 0, 0, 1, S_MEMWR_ST, 4); add(6'h2B, 0, 0, 1, S_MEMWR_ST, 4);
        add(6'h2B, 0, 0, 1, S_MEMWR_ST, 4); add(6'h2B, 0, 0, 0, S_MEMWR, 4);
        // illegal opcode, then illegal funct
        add(6'h3F, 0, 0, 0, S_FETCH, 5);   add(6'h3F, 0, 0, 0, S_DEC_ILL, 5);
        add(0, 6'h07, 0, 0, S_FETCH, 6);   add(0, 6'h07, 0, 0, S_DEC, 6);
        add(0, 6'h07, 0, 0, S_EX_ILL, 6);
        // addi
        add(6'h08, 0, 0, 0, S_FETCH, 7);   add(6'h08, 0, 0, 0, S_DEC, 7);
        add(6'h08, 0, 0, 0, S_ADDIEX, 7);  add(6'h08, 0, 0, 0, S_ADDIWB, 7);
        // j: counter wraps 7 -> 0 on the previous retire
        add(6'h02, 0, 0, 0, S_FETCH, 0);
`ifdef MIPS_CTRL_JUMP_EN
        add(6'h02, 0, 0, 0, S_DEC, 0);     add(6'h02, 0, 0, 0, S_JUMP, 0);
`else
        add(6'h02, 0, 0, 0, S_DEC_ILL, 0);
`endif
        // stall in FETCH and in an illegal DECODE
        add(6'h3F, 0, 0, 1, S_FETCH_ST, 1); add(6'h3F, 0, 0, 0, S_FETCH, 1);
        add(6'h3F, 0, 0, 1, S_DEC, 1);      add(6'h3F, 0, 0, 0, S_DEC_ILL, 1);
        // R-type and, slt
        add(0, 6'h24, 0, 0, S_FETCH, 2);   add(0, 6'h24, 0, 0, S_DEC, 2);
        add(0, 6'h24, 0, 0, S_EX_AND, 2);  add(0, 6'h24, 0, 0, S_ALUWB, 2);
        add(0, 6'h2A, 0, 0, S_FETCH, 3);   add(0, 6'h2A, 0, 0, S_DEC, 3);
        add(0, 6'h2A, 0, 0, S_EX_SLT, 3);  add(0, 6'h2A, 0, 0, S_ALUWB, 3);
        // lw up to MEMRD before the reset sequence
        add(6'h23, 0, 0, 0, S_FETCH, 4);   add(6'h23, 0, 0, 0, S_DEC, 4);
        add(6'h23, 0, 0, 0, S_MEMADR, 4);  add(6'h23, 0, 0, 0, S_MEMRD, 4);

        reset = 1'b1; Op = 0; Funct = 0; Zero = 0; stall = 0;
        repeat (3) @(posedge clk);
        #1 chk("reset", 0, S_FETCH_ST, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = 1'b0;
            Op = vecs[i].op; Funct = vecs[i].funct; Zero = vecs[i].zero; stall = vecs[i].stall;
            #1 chk("vec", i, vecs[i].exp, vecs[i].cnt);
        end

        // async reset in the middle of MEMRD aborts the lw
        #2 reset = 1'b1;
        #1 chk("rst_mid", 0, S_FETCH_ST, 0);
        @(posedge clk);
        #1 chk("rst_mid", 1, S_FETCH_ST, 0);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_rel", 0, S_FETCH, 0);
        @(negedge clk);
        #1 chk("rst_rel", 1, S_DEC, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
